// File: rtl/fp_add_arbiter_if.sv
// Request/response bundle between FP-issuing clients and the shared-adder arbiter.
// master = client side, slave = arbiter side.
interface fp_add_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [31:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational FP32 adder among NREQ clients.
// Optional macro FPADD_ARB_ZERO_BYPASS_EN: pass the non-zero operand through when the other is +-0.
module fp_add_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    fp_add_arbiter_if.slave     bus,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    input  logic [31:0]         add_sum,
    output logic [15:0]         op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic [IDW-1:0] nxt_ptr;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic [31:0]    issue_sum;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Scan offsets from far to near so the requester closest to ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (wrap_add(ptr, k) == IDW'(i) && bus.req_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_a = bus.req_a[i];
                sel_b = bus.req_b[i];
            end
        end
    end

    assign nxt_ptr = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    for (genvar g = 0; g < NREQ; g++) begin : g_rdy
        assign bus.req_ready[g] = !rst && (state == IDLE) && gnt_any && (gnt_id == IDW'(g));
    end

`ifdef FPADD_ARB_ZERO_BYPASS_EN
    // The shared adder assumes an implicit leading 1, so zero operands are handled here.
    always_comb begin
        if (add_a[30:0] == 31'd0)      issue_sum = add_b;
        else if (add_b[30:0] == 31'd0) issue_sum = add_a;
        else                           issue_sum = add_sum;
    end
`else
    assign issue_sum = add_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            add_a         <= '0;
            add_b         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        add_a      <= sel_a;
                        add_b      <= sel_b;
                        bus.rsp_id <= gnt_id;
                        ptr        <= nxt_ptr;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.rsp_data  <= issue_sum;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: ideal FP adder model, expected responses queued at accept.
module tb_fp_add_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();
  logic [31:0] add_a, add_b, add_sum;
  logic [15:0] op_count;
  logic        bad_add = 1'b0;

  fp_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .op_count(op_count)
  );

  // exact for normals and zeros with short mantissas
  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  always_comb add_sum = bad_add ? 32'hDEADBEEF : fp_add(add_a, add_b);

  function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] b);
`ifdef FPADD_ARB_ZERO_BYPASS_EN
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
`endif
    return bad_add ? 32'hDEADBEEF : fp_add(a, b);
  endfunction

  int total = 0;
  int bad   = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [IDW-1:0] id; logic [31:0] data; } rsp_t;
  rsp_t exp_q[$];
  int   grant_q[$];
  int   hs_cyc_q[$];
  int   cyc = 0, acc_cyc = 0, rdy2_cnt = 0;
  logic prev_vld = 1'b0, prev_hs = 1'b0;
  logic [31:0]    prev_data = '0, last_data = '0;
  logic [IDW-1:0] prev_id = '0;
  rsp_t e;

  // accept at edge N -> rsp_valid sampled high at edge N+2 (seen 2 negedges after the accept)
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (bus.req_ready[2]) rdy2_cnt++;
      if (|(bus.req_ready & bus.req_valid)) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) begin
          grant_q.push_back(i);
          exp_q.push_back('{id: IDW'(i), data: exp_sum(bus.req_a[i], bus.req_b[i])});
        end
        acc_cyc = cyc;
      end
      if (bus.rsp_valid) begin
        chk("rdy_in_resp", 32'(bus.req_ready), 32'd0);
        if (!prev_vld) chk("latency", 32'(cyc - acc_cyc), 32'd2);
        else if (!prev_hs) begin
          chk("hold_data", bus.rsp_data, prev_data);
          chk("hold_id", 32'(bus.rsp_id), 32'(prev_id));
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_data", bus.rsp_data, e.data);
        end
        hs_cyc_q.push_back(cyc);
        last_data = bus.rsp_data;
      end
      prev_vld  = bus.rsp_valid;
      prev_hs   = bus.rsp_valid && bus.rsp_ready;
      prev_data = bus.rsp_data;
      prev_id   = bus.rsp_id;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    bus.req_a[i] = a;
    bus.req_b[i] = b;
    bus.req_valid[i] = 1'b1;
    @(negedge clk);
    while (!bus.req_ready[i] && k < 50) begin @(negedge clk); k++; end
    chk("grant_wait", 32'(k < 50), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && k < 200) begin @(negedge clk); k++; end
    chk("drain_wait", 32'(k < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int k;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;

    // reset values, req_ready forced low even with all valids up
    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst = 1'b0;
    tick(1);

    // single request 1.0 + 1.0 from requester 2
    rdy2_cnt = 0;
    send(2, 32'h3F800000, 32'h3F800000);
    drain();
    chk("single_rdy_pulses", 32'(rdy2_cnt), 32'd1);
    chk("single_sum", last_data, 32'h40000000);
    chk("single_op_count", 32'(op_count), 32'd1);

    // round-robin with every requester asking continuously
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    grant_q.delete();
    hs_cyc_q.delete();
    bus.req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    bus.req_b = {4{32'h3F000000}};
    bus.req_valid = '1;
    k = 0;
    while (grant_q.size() < 6 && k < 100) begin @(negedge clk); k++; end
    chk("rr_wait", 32'(k < 100), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
    for (int i = 0; i < 6; i++)
      chk("rr_grant", 32'(i < grant_q.size() ? grant_q[i] : -1), 32'(exp_order[i]));
    for (int i = 1; i < 6; i++)
      chk("rr_spacing", 32'(i < hs_cyc_q.size() ? hs_cyc_q[i] - hs_cyc_q[i-1] : -1), 32'd3);

    // back-pressure: 10 cycles stalled in RESP with another requester waiting
    bus.rsp_ready = 1'b0;
    send(1, 32'h40400000, 32'h40000000);
    bus.req_a[0] = 32'h3F800000;
    bus.req_b[0] = 32'h40800000;
    bus.req_valid[0] = 1'b1;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin @(negedge clk); k++; end
    tick(10);
    chk("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
    chk("bp_no_accept", 32'(exp_q.size()), 32'd1);
    bus.rsp_ready = 1'b1;
    send(0, 32'h3F800000, 32'h40800000);
    drain();

    // reset while in ISSUE
    bus.req_a[1] = 32'h40000000;
    bus.req_b[1] = 32'h40000000;
    bus.req_valid[1] = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.req_ready[1] && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_id", 32'(bus.rsp_id), 32'd0);
    chk("mid_rst_data", bus.rsp_data, 32'd0);
    chk("mid_rst_add_a", add_a, 32'd0);
    chk("mid_rst_add_b", add_b, 32'd0);
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    grant_q.delete();
    bus.req_a[3] = 32'h40800000;
    bus.req_b[3] = 32'h3F800000;
    bus.req_a[0] = 32'h3F800000;
    bus.req_b[0] = 32'h3F800000;
    bus.req_valid = 4'b1001;
    k = 0;
    while (grant_q.size() == 0 && k < 20) begin @(negedge clk); k++; end
    chk("post_rst_grant", 32'(grant_q.size() > 0 ? grant_q[0] : -1), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // zero operand with a broken adder
    bad_add = 1'b1;
    send(2, 32'h00000000, 32'h40400000);
    drain();
`ifdef FPADD_ARB_ZERO_BYPASS_EN
    chk("zero_bypass", last_data, 32'h40400000);
`else
    chk("zero_no_bypass", last_data, 32'hDEADBEEF);
`endif
    bad_add = 1'b0;

    // saturation from a preloaded count
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    for (int i = 0; i < 3; i++) begin
      send(i, 32'h3F800000, 32'h40000000);
      drain();
      chk("sat_op_count", 32'(op_count), 32'h0000FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one combinational single-precision IEEE754 adder among `NREQ` requesters. It accepts one operand pair at a time over a valid/ready request channel and registers the operands onto the shared adder's inputs. It captures the adder's sum and returns it, tagged with the requester index, on a single valid/ready response channel. It sits between the FP-issuing client blocks and the shared adder instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `IDW`, 3: width of the requester index; must satisfy 2^`IDW` >= `NREQ`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  32*NREQ  operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  32*NREQ  operand B; same packing as `req_a`.
- `add_a`  out  32  registered operand A to the shared adder.
- `add_b`  out  32  registered operand B to the shared adder.
- `add_sum`  in  32  combinational sum from the shared adder.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.
- `rsp_data`  out  32  registered sum.
- `op_count`  out  16  completed-operation counter; saturates at 0xFFFF.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. Reset enters IDLE.
- **IDLE:**
  - Grant g is the first requester with `req_valid` set, searching from `ptr` upward and wrapping modulo `NREQ`.
  - `req_ready[g]`=1 combinationally. All other `req_ready` bits are 0.
  - When any `req_valid` is set, the transfer completes on that edge:
    - `add_a`<=`req_a[g]` and `add_b`<=`req_b[g]`.
    - `rsp_id`<=g.
    - `ptr`<=(g+1) mod `NREQ`.
    - The FSM moves to ISSUE.
- **ISSUE:** `rsp_data`<=`add_sum`, then RESP. `req_ready` is 0.
- **RESP:**
  - `rsp_valid`=1 and `req_ready`=0.
  - When `rsp_ready`=1: `rsp_valid` drops, `op_count` increments (saturating) and the FSM returns to IDLE.
- `rsp_data` and `rsp_id` are stable for as long as `rsp_valid` is high.
- The block does no arithmetic of its own. The sum is exactly `add_sum`, except under the Configuration feature.
- A requester that drops `req_valid` before being granted loses nothing; the arbiter holds no per-requester state.
- `ptr` advances only on an accept, so a requester kept waiting is served within `NREQ` grants.

## Timing
- Reset values: `req_ready`=0 (forced 0 while `rst` is high), `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `add_a`=0, `add_b`=0, `op_count`=0, `ptr`=0, state IDLE.
- Latency: an accept on edge N gives `rsp_valid`=1 from edge N+2.
- Peak throughput is one operation per 3 cycles, reached when `rsp_ready` is held at 1.
- A new request can be accepted in the cycle immediately after the RESP handshake, i.e. when back in IDLE.
- Back-pressure: while `rsp_ready`=0 the FSM stays in RESP indefinitely and no requests are accepted.
- Reset asserted mid-operation: all state returns to reset values at once and the in-flight result is discarded. No response is emitted after reset deasserts.
- Simultaneous valids: exactly one is granted per accept; the others wait.

## Configuration
- `FPADD_ARB_ZERO_BYPASS_EN` defined:
  - In ISSUE, if `add_a[30:0]`==0 (±0), `rsp_data`<=`add_b`.
  - Else if `add_b[30:0]`==0, `rsp_data`<=`add_a`.
  - Otherwise `rsp_data`<=`add_sum`.
  - If both operands are zero, `rsp_data`<=`add_b`.
  - Latency is unchanged. This works around the shared adder, which always assumes an implicit leading 1 and so mishandles zero operands.
- Macro undefined: `rsp_data`<=`add_sum` always.

## Test plan
- **Single request:** the bench adder model is an ideal FP add. Requester 2 sends A=0x3F800000 and B=0x3F800000 (1.0+1.0).
  - `req_ready[2]` pulses for one cycle.
  - `rsp_valid` goes high 2 edges after the accept, with `rsp_id`=2 and `rsp_data`=0x40000000.
  - `op_count`=1 after the response handshake.
- **Round-robin fairness:** all 4 `req_valid` held high continuously.
  - Grant order is 0,1,2,3,0,1.
  - `rsp_id` values follow the same order, with one response every 3 cycles.
- **Back-pressure:** hold `rsp_ready`=0 for 10 cycles during RESP.
  - `rsp_valid`, `rsp_data` and `rsp_id` stay constant.
  - `req_ready` stays 0.
  - The FSM resumes when `rsp_ready`=1.
- **Reset mid-operation:** assert `rst` in ISSUE.
  - All outputs go to their reset values at once, with no clock edge needed.
  - No `rsp_valid` appears after release.
  - The next grant goes to requester 0.
- **Zero bypass:** A=0x00000000, B=0x40400000, with the bench adder forced to return 0xDEADBEEF.
  - With `FPADD_ARB_ZERO_BYPASS_EN` defined: `rsp_data`=0x40400000.
  - Without it: `rsp_data`=0xDEADBEEF.
- **Saturation:** preload `op_count` to 0xFFFE via a force and complete 3 operations. `op_count` reads 0xFFFF and stays there.
